// File: rtl/quad_decoder_ext_pkg.sv
// Shared types for the quadrature decoder: counting-mode encoding.
// Mode value 3 is reserved and decodes as X4.
package quad_pkg;

  localparam int QUAD_MODE_W = 2;

  typedef enum logic [QUAD_MODE_W-1:0] {
    QUAD_X1 = 2'd0,
    QUAD_X2 = 2'd1,
    QUAD_X4 = 2'd2
  } quad_mode_t;

endpackage

// File: rtl/quad_decoder_ext_if.sv
// Encoder pins, control strobes and position/velocity results of quad_decoder_ext.
import quad_pkg::*;

interface quad_decoder_ext_if #(
  parameter int CNT_W = 32,
  parameter int PER_W = 24
);
  logic             quad_a;
  logic             quad_b;
  logic             quad_i;
  quad_mode_t       mode;
  logic             idx_clr_en;
  logic             load_en;
  logic [CNT_W-1:0] load_val;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic [CNT_W-1:0] idx_pos;
  logic             idx_seen;
  logic             err_pulse;
  logic             err_sticky;
  logic [PER_W-1:0] period;
  logic             period_valid;

  modport master (
    output quad_a, quad_b, quad_i, mode, idx_clr_en, load_en, load_val, err_clr,
    input  count, dir, step, idx_pos, idx_seen, err_pulse, err_sticky, period, period_valid
  );

  modport slave (
    input  quad_a, quad_b, quad_i, mode, idx_clr_en, load_en, load_val, err_clr,
    output count, dir, step, idx_pos, idx_seen, err_pulse, err_sticky, period, period_valid
  );
endinterface

// File: rtl/quad_decoder_ext_sync_filter.sv
// One asynchronous pin -> synchroniser chain -> run-length glitch filter.
// Latency SYNC_STAGES + FILT_LEN edges; the level tracks the synced input directly while in reset.
module quad_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_i,
  output logic dout_o
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          run_q;
  logic                   level_q;

  // Synchroniser flops carry no reset so they never sit on the reset tree.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q <= synced;
      run_q   <= '0;
    end else if (synced != level_q) begin
      if (run_q == CW'(FILT_LEN - 1)) begin
        level_q <= synced;
        run_q   <= '0;
      end else begin
        run_q <= run_q + CW'(1);
      end
    end else begin
      run_q <= '0;
    end
  end

  assign dout_o = level_q;

endmodule

// File: rtl/quad_decoder_ext.sv
// Filtered x1/x2/x4 quadrature position counter with index capture, preload and illegal-edge flags.
// Pin edge to count: SYNC_STAGES+FILT_LEN+1 clocks. Step-period measurement built only with QUAD_VELOCITY_EN.
module quad_decoder_ext
  import quad_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int PER_W       = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  quad_decoder_ext_if.slave  bus
);
  logic fa, fb, fi;

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din_i(bus.quad_a), .dout_o(fa));
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din_i(bus.quad_b), .dout_o(fb));
  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_i (
    .clk(clk), .reset_n(reset_n), .din_i(bus.quad_i), .dout_o(fi));

  logic [1:0]       ab, ab_chg, prev_ab_q;
  logic             prev_i_q;
  logic             valid_edge, illegal, up, qual, step_acc, idx_rise;
  logic [CNT_W-1:0] count_d, count_q, idx_pos_q;
  logic             dir_q, step_q, idx_seen_q, err_pulse_q, err_sticky_q;

  assign ab         = {fa, fb};
  assign ab_chg     = ab ^ prev_ab_q;
  assign valid_edge = ab_chg[1] ^ ab_chg[0];
  assign illegal    = &ab_chg;
  assign up         = fa ^ prev_ab_q[0];
  assign idx_rise   = fi & ~prev_i_q;
  assign step_acc   = qual & ~bus.load_en;

  always_comb begin
    qual = valid_edge;
    case (bus.mode)
      QUAD_X1: qual = ab_chg[1] & ~ab_chg[0] & fa;
      QUAD_X2: qual = ab_chg[1] & ~ab_chg[0];
      default: qual = valid_edge;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (bus.load_en) begin
      count_d = bus.load_val;
    end else if (idx_rise && bus.idx_clr_en) begin
      count_d = '0;
    end else if (qual) begin
      count_d = up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end
  end

  // Edge history follows the filters even in reset, so release never looks like an edge.
  always_ff @(posedge clk) begin
    prev_ab_q <= ab;
    prev_i_q  <= fi;
    if (!reset_n) begin
      count_q      <= '0;
      dir_q        <= 1'b0;
      step_q       <= 1'b0;
      idx_pos_q    <= '0;
      idx_seen_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      step_q       <= step_acc;
      idx_seen_q   <= idx_seen_q | idx_rise;
      err_pulse_q  <= illegal;
      err_sticky_q <= illegal | (err_sticky_q & ~bus.err_clr);
      if (step_acc) dir_q <= up;
      if (idx_rise) idx_pos_q <= count_q;
    end
  end

  assign bus.count      = count_q;
  assign bus.dir        = dir_q;
  assign bus.step       = step_q;
  assign bus.idx_pos    = idx_pos_q;
  assign bus.idx_seen   = idx_seen_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;

`ifdef QUAD_VELOCITY_EN
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic [PER_W-1:0] per_cnt_q, period_q;
  logic             period_vld_q, stall_q;

  // A stalled encoder reports PER_MAX once, then stays quiet until the next step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      per_cnt_q    <= PER_W'(1);
      period_q     <= PER_MAX;
      period_vld_q <= 1'b0;
      stall_q      <= 1'b0;
    end else if (step_acc) begin
      period_q     <= per_cnt_q;
      period_vld_q <= 1'b1;
      per_cnt_q    <= PER_W'(1);
      stall_q      <= 1'b0;
    end else if (per_cnt_q == PER_MAX && !stall_q) begin
      period_q     <= PER_MAX;
      period_vld_q <= 1'b1;
      stall_q      <= 1'b1;
    end else begin
      period_vld_q <= 1'b0;
      if (per_cnt_q != PER_MAX) per_cnt_q <= per_cnt_q + PER_W'(1);
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_vld_q;
`else
  assign bus.period       = {PER_W{1'b0}};
  assign bus.period_valid = 1'b0;
`endif

endmodule
